mac_acc_divider: RTL and testbench
==================================

// Module: mac_acc_divider
// PURPOSE
//   Sequential restoring divider: the inverse path to the 8-bit MAC. Takes a 16-bit
//   accumulated MAC result and an 8-bit divisor (e.g. accumulation count for averaging).
//   Returns quotient and remainder over a valid/ready handshake on both sides.
//   Produces one quotient bit per clock; sits downstream of the MAC accumulator register.
// PARAMETERS
//   DW  16  dividend and quotient width
//   SW  8   divisor and remainder width (SW <= DW)
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   reset, asynchronous, active-high
//   in_valid     in   1   dividend/divisor valid
//   in_ready     out  1   divider can accept an operation
//   dividend     in   DW  unsigned dividend (MAC accumulator value)
//   divisor      in   SW  unsigned divisor
//   out_valid    out  1   result valid
//   out_ready    in   1   consumer accepts the result
//   quotient     out  DW  unsigned quotient
//   remainder    out  SW  unsigned remainder
//   div_by_zero  out  1   divisor was zero; qualified by out_valid
// BEHAVIOUR
//   - Reset: state=IDLE. out_valid=0, quotient=0, remainder=0, div_by_zero=0.
//     in_ready=1 from the first cycle after reset.
//   - FSM states and transitions:
//     IDLE -(in_valid & divisor!=0)-> BUSY
//     IDLE -(in_valid & divisor==0)-> DONE
//     BUSY -(iteration count reaches DW)-> DONE
//     DONE -(out_ready)-> IDLE
//   - Output decoding: in_ready = (state==IDLE); out_valid = (state==DONE).
//     Both are decoded combinationally from registered state.
//   - Accept edge (in_valid & in_ready):
//     latch the dividend into a shift register and the divisor into a register;
//     clear the partial remainder (SW+1 bits); load iteration counter = DW.
//   - One BUSY iteration per edge:
//     pr' = {pr[SW-1:0], sh[DW-1]}; sh shifts left by 1.
//     If pr' >= {1'b0,divisor}: pr = pr' - divisor and shift in quotient bit 1.
//     Otherwise pr = pr' and shift in quotient bit 0.
//     The counter decrements each iteration.
//   - Latency: out_valid rises DW edges after the accept edge (16 cycles at default).
//     Divide-by-zero latency is 1 edge.
//   - Divide-by-zero result: quotient = all ones, remainder = dividend[SW-1:0],
//     div_by_zero = 1, and no iteration is performed.
//   - DONE hold: quotient, remainder and div_by_zero stay stable while out_ready=0.
//     in_ready stays 0 in DONE, so no new operation is accepted until the result is taken.
//   - Result retention: quotient and remainder keep their last value after handshake,
//     until the next result is written.
//   - Throughput: at most one operation per DW+2 cycles; no overlap of operations.
//   - Reset mid-operation: aborts immediately and returns to IDLE. No partial result
//     and no out_valid pulse appear after reset release.
//   - in_valid in BUSY/DONE is ignored; the upstream holds data until in_ready.
// STRUCTURE
//   - Shared package mac_pkg:
//     MAC_DW=16, MAC_SW=8;
//     state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
//   - Sub-module div_step (combinational):
//     in  pr[SW:0], msb, divisor[SW-1:0]
//     out pr_next[SW:0], qbit
//     One compare-subtract step.
//   - Top level holds the FSM, the counter ($clog2(DW+1) bits), the shift and result
//     registers, and one div_step instance.
// TESTING
//   1. 1000/7, out_ready=1
//      -> quotient=142, remainder=6, dbz=0; out_valid 16 cycles after accept.
//   2. 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
//      0xFFFF/0xFF -> quotient=257, remainder=0.
//   3. 5/200 (dividend < divisor) -> quotient=0, remainder=5.
//   4. 0x1234/0 -> dbz=1, quotient=0xFFFF, remainder=0x34;
//      out_valid on the cycle after accept.
//   5. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//      -> outputs stable, in_ready=0; after handshake, in_ready=1 on the next cycle.
//   6. Assert rst at BUSY iteration 8 -> out_valid=0, in_ready=1, outputs zeroed.
//      Then 50/5 -> quotient=10, remainder=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: default widths and divider FSM state encoding.
package mac_pkg;

  localparam int unsigned MAC_DW = 16;
  localparam int unsigned MAC_SW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/mac_acc_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// then compare and subtract.
module div_step #(
  parameter int unsigned SW = 8
) (
  input  logic [SW:0]   pr,
  input  logic          msb,
  input  logic [SW-1:0] divisor,
  output logic [SW:0]   pr_next,
  output logic          qbit
);

  logic [SW:0] w_shift;
  logic        w_unused;

  // The partial remainder always stays below the divisor, so its top bit is always zero.
  assign w_unused = pr[SW];
  assign w_shift  = {pr[SW-1:0], msb};
  assign qbit     = (w_shift >= {1'b0, divisor});
  assign pr_next  = qbit ? (w_shift - {1'b0, divisor}) : w_shift;

endmodule

// File: rtl/mac_acc_divider.sv
// Sequential restoring divider for MAC accumulator results: one quotient bit per clock,
// with valid/ready handshakes on the input and result sides.
module mac_acc_divider
  import mac_pkg::*;
#(
  parameter int unsigned DW = MAC_DW,
  parameter int unsigned SW = MAC_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [SW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = $clog2(DW + 1);

  div_state_t    r_state;
  logic [DW-1:0] r_sh;
  logic [SW-1:0] r_div;
  logic [SW:0]   r_pr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_quot;
  logic [SW-1:0] r_rem;
  logic          r_dbz;

  logic [SW:0]   w_pr_next;
  logic          w_qbit;

  div_step #(.SW(SW)) u_step (
    .pr      (r_pr),
    .msb     (r_sh[DW-1]),
    .divisor (r_div),
    .pr_next (w_pr_next),
    .qbit    (w_qbit)
  );

  // Handshake flags decode straight from the state register.
  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sh    <= '0;
      r_div   <= '0;
      r_pr    <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sh  <= dividend;
            r_div <= divisor;
            r_pr  <= '0;
            r_cnt <= CW'(DW);
            // A zero divisor short-circuits straight to a saturated result.
            if (divisor == '0) begin
              r_quot  <= '1;
              r_rem   <= dividend[SW-1:0];
              r_dbz   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_pr  <= w_pr_next;
          r_sh  <= {r_sh[DW-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_quot  <= {r_sh[DW-2:0], w_qbit};
            r_rem   <= w_pr_next[SW-1:0];
            r_dbz   <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_acc_divider.sv
// Bench for mac_acc_divider: table of divisions checked through a result scoreboard,
// plus backpressure and mid-operation reset sequences.
module tb_mac_acc_divider;

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 8;

  typedef struct {
    logic [DW-1:0] dvd;
    logic [SW-1:0] dvs;
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
    int            hold;
  } vec_t;

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
    int            edges;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t vecs[8];

  mac_acc_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_op(input vec_t v);
    exp_t e;
    exp_t got;
    int   waitc;
    int   edges;
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    dividend  = v.dvd;
    divisor   = v.dvs;
    in_valid  = 1'b1;
    out_ready = (v.hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.q     = v.q;
    e.r     = v.r;
    e.dbz   = v.dbz;
    e.edges = (v.dvs == '0) ? 0 : DW;
    sb.push_back(e);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    got = sb.pop_front();
    chk("latency", 32'(edges), 32'(got.edges));
    chk("quotient", 32'(quotient), 32'(got.q));
    chk("remainder", 32'(remainder), 32'(got.r));
    chk("div_by_zero", 32'(div_by_zero), 32'(got.dbz));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_result", {7'(0), div_by_zero, remainder, quotient}, {7'(0), got.dbz, got.r, got.q});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("retain_result", {8'(0), remainder, quotient}, {8'(0), got.r, got.q});
  endtask

  initial begin
    int seen;
    vecs[0] = '{dvd: 16'd1000,  dvs: 8'd7,    q: 16'd142,   r: 8'd6,    dbz: 1'b0, hold: 0};
    vecs[1] = '{dvd: 16'hFFFF,  dvs: 8'd1,    q: 16'hFFFF,  r: 8'd0,    dbz: 1'b0, hold: 0};
    vecs[2] = '{dvd: 16'hFFFF,  dvs: 8'hFF,   q: 16'd257,   r: 8'd0,    dbz: 1'b0, hold: 5};
    vecs[3] = '{dvd: 16'd5,     dvs: 8'd200,  q: 16'd0,     r: 8'd5,    dbz: 1'b0, hold: 0};
    vecs[4] = '{dvd: 16'h1234,  dvs: 8'd0,    q: 16'hFFFF,  r: 8'h34,   dbz: 1'b1, hold: 3};
    vecs[5] = '{dvd: 16'd0,     dvs: 8'd3,    q: 16'd0,     r: 8'd0,    dbz: 1'b0, hold: 0};
    vecs[6] = '{dvd: 16'd12345, dvs: 8'd255,  q: 16'd48,    r: 8'd105,  dbz: 1'b0, hold: 1};
    vecs[7] = '{dvd: 16'h8000,  dvs: 8'h80,   q: 16'd256,   r: 8'd0,    dbz: 1'b0, hold: 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", {7'(0), div_by_zero, remainder, quotient}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Abort an operation part-way through the iterations.
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back('{q: 16'd142, r: 8'd6, dbz: 1'b0, edges: DW});
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", {7'(0), div_by_zero, remainder, quotient}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_idle", 32'(in_ready), 32'd1);
    do_op('{dvd: 16'd50, dvs: 8'd5, q: 16'd10, r: 8'd0, dbz: 1'b0, hold: 0});

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
